// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared opcode/funct constants and the instruction decoder used
// by the ALU issue stage.
//   decode_t      : destination register, source usage and class flags
//   decode_instr(): MIPS subset decode; illegal encodings yield dest 0 and no
//                   source usage so they never touch or wait on the scoreboard.
package alu_issue_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpSltiu = 6'h0b;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;

    typedef struct packed {
        logic [4:0] dest;
        logic       use_rs;
        logic       use_rt;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       illegal;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [5:0] op;
        logic [5:0] funct;
        op    = instr[31:26];
        funct = instr[5:0];
        d     = '0;
        case (op)
            OpRtype: begin
                case (funct)
                    // Immediate shifts take their amount from shamt, not rs.
                    FnSll, FnSrl, FnSra: begin
                        d.dest   = instr[15:11];
                        d.use_rt = 1'b1;
                    end
                    FnSllv, FnSrlv, FnSrav, FnAdd, FnAddu, FnSub, FnSubu,
                    FnAnd, FnOr, FnXor, FnNor, FnSlt, FnSltu: begin
                        d.dest   = instr[15:11];
                        d.use_rs = 1'b1;
                        d.use_rt = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: begin
                d.dest   = instr[20:16];
                d.use_rs = 1'b1;
            end
            OpLw: begin
                d.dest    = instr[20:16];
                d.use_rs  = 1'b1;
                d.is_load = 1'b1;
            end
            OpSw: begin
                d.use_rs   = 1'b1;
                d.use_rt   = 1'b1;
                d.is_store = 1'b1;
            end
            OpBeq, OpBne: begin
                d.use_rs    = 1'b1;
                d.use_rt    = 1'b1;
                d.is_branch = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_regfile.sv
// issue_regfile: 32x32 register file for the issue stage.
//   clk_i/reset_i         : clock, synchronous active-high reset (clears all entries)
//   raddr1_i/rdata1_o     : combinational read port 1
//   raddr2_i/rdata2_o     : combinational read port 2
//   we_i/waddr_i/wdata_i  : synchronous write port
// Register 0 reads as zero and ignores writes. With BYPASS != 0 a read of the
// register being written this cycle returns the incoming write data.
module issue_regfile #(
    parameter int unsigned BYPASS = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];
    logic        fwd1;
    logic        fwd2;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign fwd1 = (BYPASS != 0) && we_i && (waddr_i == raddr1_i);
    assign fwd2 = (BYPASS != 0) && we_i && (waddr_i == raddr2_i);

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : (fwd1 ? wdata_i : regs_q[raddr1_i]);
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : (fwd2 ? wdata_i : regs_q[raddr2_i]);

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/operand-issue stage in front of the ALU.
//   clk, reset (sync, active-high)
//   in_valid/in_ready/in_instr       : upstream instruction handshake
//   wb_en/wb_addr/wb_data            : register writeback port
//   flush                            : drop the held output instruction
//   out_valid/out_ready              : downstream handshake
//   out_instr/out_reg1/out_reg2      : instruction plus rs/rt values
//   out_dest, out_is_load/store/branch, out_illegal : decoded control
// Optional: define ALU_ISSUE_STATS_EN to add stat_issued/stat_stalls counters.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int unsigned STAT_W = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_reg1,
    output logic [31:0]       out_reg2,
    output logic [4:0]        out_dest,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic              out_is_branch,
`ifdef ALU_ISSUE_STATS_EN
    output logic [STAT_W-1:0] stat_issued,
    output logic [STAT_W-1:0] stat_stalls,
`endif
    output logic              out_illegal
);

    decode_t     dec;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rs_haz;
    logic        rt_haz;
    logic        hazard;
    logic        accept;

    logic [31:0] pending_q, pending_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] reg1_q, reg1_d;
    logic [31:0] reg2_q, reg2_d;
    decode_t     dec_q, dec_d;

    assign rs  = in_instr[25:21];
    assign rt  = in_instr[20:16];
    assign dec = decode_instr(in_instr);

    issue_regfile #(
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk_i    (clk),
        .reset_i  (reset),
        .raddr1_i (rs),
        .rdata1_o (rdata1),
        .raddr2_i (rt),
        .rdata2_o (rdata2),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // A source landing on the writeback port this cycle is not a hazard when
    // the register file forwards it.
    assign rs_haz = dec.use_rs && (rs != 5'd0) && pending_q[rs] &&
                    !(wb_en && (wb_addr == rs) && (BYPASS != 0));
    assign rt_haz = dec.use_rt && (rt != 5'd0) && pending_q[rt] &&
                    !(wb_en && (wb_addr == rt) && (BYPASS != 0));
    assign hazard = rs_haz || rt_haz;

    assign in_ready = !hazard && (!valid_q || out_ready) && !reset && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_addr] = 1'b0;
        end
        // A flushed instruction will never write back, so release its claim.
        if (flush && valid_q && (dec_q.dest != 5'd0)) begin
            pending_d[dec_q.dest] = 1'b0;
        end
        // Applied last so a new claim beats a same-cycle writeback clear.
        if (accept && (dec.dest != 5'd0)) begin
            pending_d[dec.dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        dec_d   = dec_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            reg1_d  = rdata1;
            reg2_d  = rdata2;
            dec_d   = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            dec_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            dec_q     <= dec_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_instr     = instr_q;
    assign out_reg1      = reg1_q;
    assign out_reg2      = reg2_q;
    assign out_dest      = dec_q.dest;
    assign out_is_load   = dec_q.is_load;
    assign out_is_store  = dec_q.is_store;
    assign out_is_branch = dec_q.is_branch;
    assign out_illegal   = dec_q.illegal;

    // Source-usage bits only steer the hazard check; they are not issued.
    logic unused_dec;
    assign unused_dec = dec_q.use_rs ^ dec_q.use_rt;

`ifdef ALU_ISSUE_STATS_EN
    logic [STAT_W-1:0] issued_q, issued_d;
    logic [STAT_W-1:0] stalls_q, stalls_d;

    always_comb begin
        issued_d = issued_q;
        stalls_d = stalls_q;
        if (accept && (issued_q != '1)) begin
            issued_d = issued_q + 1'b1;
        end
        if (in_valid && hazard && (stalls_q != '1)) begin
            stalls_d = stalls_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            issued_q <= issued_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stalls = stalls_q;
`else
    logic unused_stat_w;
    assign unused_stat_w = (STAT_W == 0);
`endif

endmodule
